// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control unit.
// Sequences FETCH/DECODE/execute/writeback states and drives datapath enables
// and mux selects decoded from the current state. A wait counter bounds every
// memory access; an overlong wait or an unknown opcode parks the FSM in ERROR
// with a sticky flag until reset.
// Optional feature: define RV_JAL_EN to add the JAL state (opcode 1101111).
// Without it, 1101111 is treated as an illegal opcode.
//
// Handshake: mem_ready is a single-cycle "access complete" strobe sampled on
// the rising edge while the FSM sits in FETCH, MEMREAD or MEMWRITE. mem_read
// or mem_write is held high for the whole access, and the FSM leaves the
// access state on the edge where mem_ready=1 is sampled.
module multicycle_control_unit #(
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_update,
  output logic               branch,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               adr_src,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic               timeout,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
`ifdef RV_JAL_EN
    S_JAL      = 4'd10,
`endif
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  // Counter only needs to reach TIMEOUT_CYC-1; it saturates when the
  // timeout is disabled so it never wraps back to a stale value.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_wait;
  logic             timeout_hit;
  logic             set_illegal;
  logic             set_timeout;
  logic             illegal_q;
  logic             timeout_q;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

  // Memory-waiting states, and the cycle on which the wait limit expires.
  always_comb begin
    is_wait     = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);
    timeout_hit = TO_EN && is_wait && !mem_ready && (wait_cnt == CNT_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Wait counter: cleared on any state change, counts cycles without mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   wait_cnt <= '0;
    else if (state_d != state_q)                 wait_cnt <= '0;
    else if (is_wait && !mem_ready && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

  // Next-state logic; mem_ready on the limit cycle wins over the timeout.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (timeout_hit) begin
          state_d     = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
`ifdef RV_JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default: begin
            state_d     = S_ERROR;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout_hit) begin
          state_d     = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else if (timeout_hit) begin
          state_d     = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef RV_JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  // Datapath controls decoded from state; FETCH strobes follow mem_ready.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_FN;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_FN;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
`ifdef RV_JAL_EN
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (TIMEOUT_CYC=4).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       mem_ready = 1'b1;
  logic       pc_update, branch, ir_write, mem_read, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       illegal, timeout;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUOP_W(2), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .adr_src(adr_src), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .timeout(timeout), .state(state)
  );

  // Reset with the current opcode/mem_ready; returns just after release.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got state=%0d ill=%b to=%b exp 0 0 0", state, illegal, timeout);
    end
    checks++;
    if ({mem_read, ir_write, pc_update, mem_write, reg_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 10000", {mem_read, ir_write, pc_update, mem_write, reg_write});
    end
  endtask

  // States 0,1,6,8,0; reg_write only in 8; alu_op=10 in 6.
  task automatic test_rtype();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    opcode = 7'b0110011;
    mem_ready = 1'b1;
    do_reset();
    checks++;
    if (ir_write !== 1'b1 || pc_update !== 1'b1) begin
      errors++;
      $display("FAIL rtype_fetch_strobes got ir=%b pc=%b exp 1 1", ir_write, pc_update);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i] || reg_write !== (exp_s[i] == 4'd8)) begin
        errors++;
        $display("FAIL rtype_seq[%0d] got state=%0d rw=%b exp %0d %b", i, state, reg_write, exp_s[i], exp_s[i] == 4'd8);
      end
      if (i == 2) begin
        checks++;
        if (alu_op !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
          errors++;
          $display("FAIL rtype_exec got op=%b a=%b b=%b exp 10 10 00", alu_op, alu_src_a, alu_src_b);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    opcode = 7'b0010011;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL itype_seq[%0d] got %0d exp %0d", i, state, exp_s[i]);
      end
      if (i == 1) begin
        checks++;
        if (alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || alu_op !== 2'b00) begin
          errors++;
          $display("FAIL decode_sel got a=%b b=%b op=%b exp 01 01 00", alu_src_a, alu_src_b, alu_op);
        end
      end
      if (i == 2) begin
        checks++;
        if (alu_src_b !== 2'b01 || alu_op !== 2'b10) begin
          errors++;
          $display("FAIL itype_exec got b=%b op=%b exp 01 10", alu_src_b, alu_op);
        end
      end
    end
  endtask

  task automatic test_store();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i] || mem_write !== (exp_s[i] == 4'd5)) begin
        errors++;
        $display("FAIL store_seq[%0d] got state=%0d mw=%b exp %0d %b", i, state, mem_write, exp_s[i], exp_s[i] == 4'd5);
      end
      if (i == 3) begin
        checks++;
        if (adr_src !== 1'b1 || mem_read !== 1'b0) begin
          errors++;
          $display("FAIL store_memwrite got adr=%b mr=%b exp 1 0", adr_src, mem_read);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    opcode = 7'b1100011;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i] || branch !== (exp_s[i] == 4'd9)) begin
        errors++;
        $display("FAIL branch_seq[%0d] got state=%0d br=%b exp %0d %b", i, state, branch, exp_s[i], exp_s[i] == 4'd9);
      end
      if (i == 2) begin
        checks++;
        if (alu_op !== 2'b01 || alu_src_a !== 2'b10) begin
          errors++;
          $display("FAIL branch_alu got op=%b a=%b exp 01 10", alu_op, alu_src_a);
        end
      end
    end
  endtask

  // Load with 3 wait cycles; ready arrives on the limit cycle and must win.
  task automatic test_load_wait();
    opcode = 7'b0000011;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++;
    if (state !== 4'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin
      errors++;
      $display("FAIL load_memadr got state=%0d a=%b b=%b exp 2 10 01", state, alu_src_a, alu_src_b);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (state !== 4'd3 || mem_read !== 1'b1 || adr_src !== 1'b1) begin
        errors++;
        $display("FAIL load_memread[%0d] got state=%0d mr=%b adr=%b exp 3 1 1", i, state, mem_read, adr_src);
      end
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (state !== 4'd4 || result_src !== 2'b01 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL load_memwb got state=%0d rs=%b rw=%b exp 4 01 1", state, result_src, reg_write);
    end
    step();
    checks++;
    if (state !== 4'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL load_return got state=%0d to=%b exp 0 0", state, timeout);
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input string tag);
    opcode = op;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++;
    if (state !== 4'd11 || illegal !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_error got state=%0d ill=%b to=%b exp 11 1 0", tag, state, illegal, timeout);
    end
    opcode = 7'b0110011;
    repeat (3) step();
    checks++;
    if (state !== 4'd11 || illegal !== 1'b1 ||
        {pc_update, branch, ir_write, mem_read, mem_write, reg_write} !== 6'b0) begin
      errors++;
      $display("FAIL %s_hold got state=%0d ill=%b en=%b exp 11 1 000000", tag, state, illegal,
               {pc_update, branch, ir_write, mem_read, mem_write, reg_write});
    end
  endtask

  task automatic test_jal();
`ifdef RV_JAL_EN
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    opcode = 7'b1101111;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL jal_seq[%0d] got %0d exp %0d", i, state, exp_s[i]);
      end
      if (i == 2) begin
        checks++;
        if (pc_update !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin
          errors++;
          $display("FAIL jal_ctrl got pc=%b a=%b b=%b exp 1 01 10", pc_update, alu_src_a, alu_src_b);
        end
      end
    end
`else
    test_illegal(7'b1101111, "jal_off");
`endif
  endtask

  // FETCH with no ready: 4 FETCH cycles, then ERROR with timeout until reset.
  task automatic test_timeout();
    opcode = 7'b0110011;
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 4'd0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[%0d] got state=%0d to=%b exp 0 0", i, state, timeout);
      end
    end
    step();
    checks++;
    if (state !== 4'd11 || timeout !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit got state=%0d to=%b ill=%b exp 11 1 0", state, timeout, illegal);
    end
    mem_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (state !== 4'd11 || timeout !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold got state=%0d to=%b mr=%b exp 11 1 0", state, timeout, mem_read);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got state=%0d to=%b exp 0 0", state, timeout);
    end
  endtask

  // Reset asserted mid-MEMWRITE acts before the next edge.
  task automatic test_reset_mid_write();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    mem_ready = 1'b0;
    step();
    checks++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL midwr_in got state=%0d mw=%b exp 5 1", state, mem_write);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL midwr_reset got state=%0d mw=%b rw=%b exp 0 0 0", state, mem_write, reg_write);
    end
    opcode = 7'b0110011;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    checks++;
    if (state !== 4'd6) begin
      errors++;
      $display("FAIL midwr_resume got state=%0d exp 6", state);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_store();
    test_branch();
    test_load_wait();
    test_illegal(7'b1111111, "illegal");
    test_jal();
    test_timeout();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

endmodule
